// File: rtl/pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// pipeline_stall_ctrl
//
// Purpose:
//   Consumer end of the hazard signalling. It combines the hazard unit's
//   load-use stall request with the memory handshakes, branch redirects and
//   halt, and produces the latch enable and flush controls for the PC, IF/ID,
//   ID/EX, EX/MEM and MEM/WB stages. It also holds the state that the
//   combinational hazard logic cannot hold:
//     RUN    - normal operation
//     SQUASH - a taken branch redirected the PC while a fetch was still
//              outstanding; that returning word is wrong-path and gets dropped
//     HALTED - terminal state, left only through reset
//
//   Row priority, highest first: HALTED, data wait, branch_taken, hu_stall,
//   instruction miss / squash. The first matching row sets the outputs.
//   Control outputs are combinational from state and inputs.
//
// Optional feature (macro STALL_STATS_EN):
//   Adds the parameter CNT_W and the saturating counters lu_cnt, dwait_cnt and
//   flush_cnt. These count the cycles in which the load-use row, the data-wait
//   row and the branch row are active. The counters freeze in HALTED. Without
//   the macro, the ports and counters do not exist and the control behaviour
//   is unchanged.
//
// Ports:
//   CLK          in   system clock, rising edge
//   nRST         in   synchronous active-low reset
//   hu_stall     in   load-use stall request from the hazard unit
//   ihit         in   instruction memory returned valid data this cycle
//   dhit         in   data memory completed its access this cycle
//   dmem_req     in   EX/MEM holds a load or a store
//   branch_taken in   taken branch/jump resolved in EX
//   halt         in   halt instruction present in MEM/WB
//   pc_en        out  PC load enable
//   ifid_en      out  IF/ID latch enable
//   ifid_flush   out  IF/ID load bubble
//   idex_en      out  ID/EX latch enable
//   idex_flush   out  ID/EX load bubble
//   exmem_en     out  EX/MEM latch enable
//   memwb_en     out  MEM/WB latch enable
//   memwb_flush  out  MEM/WB load bubble
//   lu_cnt, dwait_cnt, flush_cnt  out  statistics (STALL_STATS_EN only)
//   halted       out  processor halted
// -----------------------------------------------------------------------------
module pipeline_stall_ctrl
`ifdef STALL_STATS_EN
#(
    parameter int CNT_W = 16
)
`endif
(
    input  logic CLK,
    input  logic nRST,
    input  logic hu_stall,
    input  logic ihit,
    input  logic dhit,
    input  logic dmem_req,
    input  logic branch_taken,
    input  logic halt,
    output logic pc_en,
    output logic ifid_en,
    output logic ifid_flush,
    output logic idex_en,
    output logic idex_flush,
    output logic exmem_en,
    output logic memwb_en,
    output logic memwb_flush,
`ifdef STALL_STATS_EN
    output logic [CNT_W-1:0] lu_cnt,
    output logic [CNT_W-1:0] dwait_cnt,
    output logic [CNT_W-1:0] flush_cnt,
`endif
    output logic halted
);

    typedef enum logic [1:0] {
        RUN    = 2'd0,
        SQUASH = 2'd1,
        HALTED = 2'd2
    } state_t;

    state_t state_reg;
    state_t state_next;

    logic dwait;
    logic row_halt;
    logic row_dwait;
    logic row_branch;
    logic row_lu;
    logic row_fetch;

    // A memory access that has not completed freezes everything up to EX/MEM.
    assign dwait = dmem_req & ~dhit;

    // One-hot row decode following the priority order. The instruction miss
    // row and the SQUASH-with-hit row drive identical outputs, so they are
    // merged into row_fetch; only their next-state effect differs.
    always_comb begin
        row_halt   = (state_reg == HALTED);
        row_dwait  = ~row_halt & dwait;
        row_branch = ~row_halt & ~dwait & branch_taken;
        row_lu     = ~row_halt & ~dwait & ~branch_taken & hu_stall;
        row_fetch  = ~row_halt & ~dwait & ~branch_taken & ~hu_stall
                   & (~ihit | (state_reg == SQUASH));
    end

    // Control outputs.
    always_comb begin
        pc_en       = 1'b0;
        ifid_en     = 1'b0;
        ifid_flush  = 1'b0;
        idex_en     = 1'b0;
        idex_flush  = 1'b0;
        exmem_en    = 1'b0;
        memwb_en    = 1'b0;
        memwb_flush = 1'b0;
        halted      = 1'b0;
        if (nRST) begin
            if (row_halt) begin
                halted = 1'b1;
            end else if (row_dwait) begin
                // Let the older instruction in MEM/WB retire, but follow it
                // with a bubble so it is not written back twice.
                memwb_en    = 1'b1;
                memwb_flush = 1'b1;
            end else if (row_branch) begin
                pc_en      = 1'b1;
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (row_lu) begin
                // Hold PC and IF/ID, and insert a bubble into ID/EX.
                idex_en    = 1'b1;
                idex_flush = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else if (row_fetch) begin
                // No usable instruction this cycle: hold the PC and feed a
                // bubble into IF/ID while the rest of the pipe drains on.
                ifid_en    = 1'b1;
                ifid_flush = 1'b1;
                idex_en    = 1'b1;
                exmem_en   = 1'b1;
                memwb_en   = 1'b1;
            end else begin
                pc_en    = 1'b1;
                ifid_en  = 1'b1;
                idex_en  = 1'b1;
                exmem_en = 1'b1;
                memwb_en = 1'b1;
            end
        end
    end

    // Next state. A branch that redirects the PC while the fetch is still
    // outstanding enters SQUASH. SQUASH is left on the first ihit that is
    // either dropped by the IF/ID bubble or blocked by the held IF/ID.
    // A branch or a data wait seen in SQUASH keeps the state. halt overrides
    // every other transition.
    always_comb begin
        state_next = state_reg;
        if (state_reg != HALTED) begin
            if (row_branch && !ihit) begin
                state_next = SQUASH;
            end else if ((state_reg == SQUASH) && ihit && (row_lu || row_fetch)) begin
                state_next = RUN;
            end
            if (halt) begin
                state_next = HALTED;
            end
        end
    end

    always_ff @(posedge CLK) begin
        if (!nRST) begin
            state_reg <= RUN;
        end else begin
            state_reg <= state_next;
        end
    end

`ifdef STALL_STATS_EN
    // Per-row cycle counters. The rows are never active in HALTED, so the
    // counters freeze there without any extra qualification.
    logic [2:0] cnt_hit;
    assign cnt_hit = {row_branch, row_dwait, row_lu};

    genvar gi;
    generate
        for (gi = 0; gi < 3; gi++) begin : gen_cnt
            logic [CNT_W-1:0] cnt_reg;
            always_ff @(posedge CLK) begin
                if (!nRST) begin
                    cnt_reg <= '0;
                end else if (cnt_hit[gi] && (cnt_reg != {CNT_W{1'b1}})) begin
                    cnt_reg <= cnt_reg + CNT_W'(1);
                end
            end
        end
    endgenerate

    assign lu_cnt    = gen_cnt[0].cnt_reg;
    assign dwait_cnt = gen_cnt[1].cnt_reg;
    assign flush_cnt = gen_cnt[2].cnt_reg;
`else
    // Control-only build: no statistics state.
`endif

endmodule

// File: tb/tb_pipeline_stall_ctrl.sv
// -----------------------------------------------------------------------------
// tb_pipeline_stall_ctrl
//
// Scenario tasks drive the inputs one cycle at a time, shortly after the rising
// edge. Each task pushes the expected output word onto a scoreboard queue, then
// pops the word and compares it on the falling edge. One line is printed per
// transaction.
//
// Stimulus word: {nRST, hu_stall, ihit, dhit, dmem_req, branch_taken, halt}
// Output word:   {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
//                 exmem_en, memwb_en, memwb_flush, halted}
// -----------------------------------------------------------------------------
module tb_pipeline_stall_ctrl;

    logic clk = 1'b0;
    logic nrst = 1'b0;
    logic hu_stall = 1'b0;
    logic ihit = 1'b0;
    logic dhit = 1'b0;
    logic dmem_req = 1'b0;
    logic branch_taken = 1'b0;
    logic halt = 1'b0;
    logic pc_en, ifid_en, ifid_flush, idex_en, idex_flush;
    logic exmem_en, memwb_en, memwb_flush, halted;

    int checks = 0;
    int errors = 0;
    logic [8:0] sb [$];

    // Stimulus words.
    localparam logic [6:0] S_IDLE    = 7'b1010000;
    localparam logic [6:0] S_LU      = 7'b1110000;
    localparam logic [6:0] S_DWALL   = 7'b1110110; // dwait with hu_stall + branch
    localparam logic [6:0] S_DHITALL = 7'b1111110; // dhit arrives, hu_stall + branch
    localparam logic [6:0] S_BRMISS  = 7'b1000010;
    localparam logic [6:0] S_BRHIT   = 7'b1010010;
    localparam logic [6:0] S_MISS    = 7'b1000000;
    localparam logic [6:0] S_HALT    = 7'b1010001;
    localparam logic [6:0] S_DW      = 7'b1010100;
    localparam logic [6:0] S_DWHALT  = 7'b1010101;
    localparam logic [6:0] S_RST     = 7'b0111111;

    // Expected output words.
    localparam logic [8:0] O_ZERO = 9'b000000000;
    localparam logic [8:0] O_NORM = 9'b110101100;
    localparam logic [8:0] O_LU   = 9'b000111100;
    localparam logic [8:0] O_DW   = 9'b000000110;
    localparam logic [8:0] O_BR   = 9'b111111100;
    localparam logic [8:0] O_MISS = 9'b011101100;
    localparam logic [8:0] O_HLT  = 9'b000000001;

`ifdef STALL_STATS_EN
    logic [15:0] lu_cnt, dwait_cnt, flush_cnt;
    logic [1:0]  lu_cnt2, dwait_cnt2, flush_cnt2;
    logic        pc_en2, ifid_en2, ifid_flush2, idex_en2, idex_flush2;
    logic        exmem_en2, memwb_en2, memwb_flush2, halted2;
    int          cnt_sb [$];
`endif

    pipeline_stall_ctrl dut (
        .CLK          (clk),
        .nRST         (nrst),
        .hu_stall     (hu_stall),
        .ihit         (ihit),
        .dhit         (dhit),
        .dmem_req     (dmem_req),
        .branch_taken (branch_taken),
        .halt         (halt),
        .pc_en        (pc_en),
        .ifid_en      (ifid_en),
        .ifid_flush   (ifid_flush),
        .idex_en      (idex_en),
        .idex_flush   (idex_flush),
        .exmem_en     (exmem_en),
        .memwb_en     (memwb_en),
        .memwb_flush  (memwb_flush),
`ifdef STALL_STATS_EN
        .lu_cnt       (lu_cnt),
        .dwait_cnt    (dwait_cnt),
        .flush_cnt    (flush_cnt),
`endif
        .halted       (halted)
    );

`ifdef STALL_STATS_EN
    pipeline_stall_ctrl #(.CNT_W(2)) dut_sat (
        .CLK          (clk),
        .nRST         (nrst),
        .hu_stall     (hu_stall),
        .ihit         (ihit),
        .dhit         (dhit),
        .dmem_req     (dmem_req),
        .branch_taken (branch_taken),
        .halt         (halt),
        .pc_en        (pc_en2),
        .ifid_en      (ifid_en2),
        .ifid_flush   (ifid_flush2),
        .idex_en      (idex_en2),
        .idex_flush   (idex_flush2),
        .exmem_en     (exmem_en2),
        .memwb_en     (memwb_en2),
        .memwb_flush  (memwb_flush2),
        .lu_cnt       (lu_cnt2),
        .dwait_cnt    (dwait_cnt2),
        .flush_cnt    (flush_cnt2),
        .halted       (halted2)
    );
`endif

    always #5 clk = ~clk;

    initial begin
        #500000;
        $display("FAIL watchdog: simulation time limit expired");
        $fatal(1, "watchdog");
    end

    function automatic logic [8:0] outs();
        return {pc_en, ifid_en, ifid_flush, idex_en, idex_flush,
                exmem_en, memwb_en, memwb_flush, halted};
    endfunction

    // Drive one stimulus word just after the next rising edge.
    task automatic apply(input logic [6:0] s);
        @(posedge clk);
        #1;
        {nrst, hu_stall, ihit, dhit, dmem_req, branch_taken, halt} = s;
    endtask

    task automatic test_reset();
        logic [6:0] stim [3] = '{S_RST, S_RST, S_IDLE};
        logic [8:0] expv [3] = '{O_ZERO, O_ZERO, O_NORM};
        logic [8:0] got, want;
        for (int i = 0; i < 3; i++) begin
            apply(stim[i]);
            sb.push_back(expv[i]);
            @(negedge clk);
            got = outs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset[%0d] in=%b got=%b want=%b", i, stim[i], got, want);
            end else $display("ok   reset[%0d] in=%b out=%b", i, stim[i], got);
        end
    endtask

    task automatic test_load_use();
        logic [6:0] stim [3] = '{S_LU, S_IDLE, S_IDLE};
        logic [8:0] expv [3] = '{O_LU, O_NORM, O_NORM};
        logic [8:0] got, want;
        for (int i = 0; i < 3; i++) begin
            apply(stim[i]);
            sb.push_back(expv[i]);
            @(negedge clk);
            got = outs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL load_use[%0d] in=%b got=%b want=%b", i, stim[i], got, want);
            end else $display("ok   load_use[%0d] in=%b out=%b", i, stim[i], got);
        end
    endtask

    task automatic test_dwait();
        logic [6:0] stim [5] = '{S_DWALL, S_DWALL, S_DWALL, S_DHITALL, S_IDLE};
        logic [8:0] expv [5] = '{O_DW, O_DW, O_DW, O_BR, O_NORM};
        logic [8:0] got, want;
        for (int i = 0; i < 5; i++) begin
            apply(stim[i]);
            sb.push_back(expv[i]);
            @(negedge clk);
            got = outs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL dwait[%0d] in=%b got=%b want=%b", i, stim[i], got, want);
            end else $display("ok   dwait[%0d] in=%b out=%b", i, stim[i], got);
        end
    endtask

    task automatic test_squash();
        logic [6:0] stim [15] = '{
            S_BRMISS, S_MISS, S_MISS, S_IDLE, S_IDLE,   // basic squash
            S_BRMISS, S_LU, S_IDLE,                     // load-use exits SQUASH
            S_BRMISS, S_DW, S_IDLE, S_IDLE,             // dwait keeps SQUASH
            S_BRMISS, S_BRHIT, S_IDLE};                 // branch keeps SQUASH
        logic [8:0] expv [15] = '{
            O_BR, O_MISS, O_MISS, O_MISS, O_NORM,
            O_BR, O_LU, O_NORM,
            O_BR, O_DW, O_MISS, O_NORM,
            O_BR, O_BR, O_MISS};
        logic [8:0] got, want;
        for (int i = 0; i < 15; i++) begin
            apply(stim[i]);
            sb.push_back(expv[i]);
            @(negedge clk);
            got = outs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL squash[%0d] in=%b got=%b want=%b", i, stim[i], got, want);
            end else $display("ok   squash[%0d] in=%b out=%b", i, stim[i], got);
        end
        // Leave SQUASH (the last IDLE above dropped the wrong-path word).
        apply(S_IDLE);
        sb.push_back(O_NORM);
        @(negedge clk);
        got = outs();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL squash_exit got=%b want=%b", got, want);
        end else $display("ok   squash_exit out=%b", got);
    endtask

    task automatic test_halt();
        logic [6:0] pre [1] = '{S_HALT};
        logic [8:0] pre_e [1] = '{O_NORM};
        logic [6:0] post [10] = '{S_RST, S_IDLE, S_DWHALT, S_IDLE, S_RST,
                                  S_BRMISS, S_HALT, S_IDLE, S_RST, S_IDLE};
        logic [8:0] post_e [10] = '{O_ZERO, O_NORM, O_DW, O_HLT, O_ZERO,
                                    O_BR, O_MISS, O_HLT, O_ZERO, O_NORM};
        logic [8:0] got, want;
        logic [6:0] r;
        apply(pre[0]);
        sb.push_back(pre_e[0]);
        @(negedge clk);
        got = outs();
        want = sb.pop_front();
        checks++;
        if (got !== want) begin
            errors++;
            $display("FAIL halt_entry in=%b got=%b want=%b", pre[0], got, want);
        end else $display("ok   halt_entry in=%b out=%b", pre[0], got);
        for (int i = 0; i < 12; i++) begin
            r = {1'b1, 6'($urandom)};
            apply(r);
            sb.push_back(O_HLT);
            @(negedge clk);
            got = outs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL halted[%0d] in=%b got=%b want=%b", i, r, got, want);
            end else $display("ok   halted[%0d] in=%b out=%b", i, r, got);
        end
        for (int i = 0; i < 10; i++) begin
            apply(post[i]);
            sb.push_back(post_e[i]);
            @(negedge clk);
            got = outs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL halt_seq[%0d] in=%b got=%b want=%b", i, post[i], got, want);
            end else $display("ok   halt_seq[%0d] in=%b out=%b", i, post[i], got);
        end
    endtask

    task automatic test_reset_squash();
        logic [6:0] stim [4] = '{S_BRMISS, S_RST, S_IDLE, S_IDLE};
        logic [8:0] expv [4] = '{O_BR, O_ZERO, O_NORM, O_NORM};
        logic [8:0] got, want;
        for (int i = 0; i < 4; i++) begin
            apply(stim[i]);
            sb.push_back(expv[i]);
            @(negedge clk);
            got = outs();
            want = sb.pop_front();
            checks++;
            if (got !== want) begin
                errors++;
                $display("FAIL reset_squash[%0d] in=%b got=%b want=%b", i, stim[i], got, want);
            end else $display("ok   reset_squash[%0d] in=%b out=%b", i, stim[i], got);
        end
    endtask

`ifdef STALL_STATS_EN
    task automatic test_stats();
        int got_c [6];
        int want_c;
        apply(S_RST);
        apply(S_IDLE);
        @(negedge clk);
        for (int k = 0; k < 6; k++) cnt_sb.push_back(0);
        got_c = '{int'(lu_cnt), int'(dwait_cnt), int'(flush_cnt),
                  int'(lu_cnt2), int'(dwait_cnt2), int'(flush_cnt2)};
        for (int k = 0; k < 6; k++) begin
            want_c = cnt_sb.pop_front();
            checks++;
            if (got_c[k] !== want_c) begin
                errors++;
                $display("FAIL stats_reset[%0d] got=%0d want=%0d", k, got_c[k], want_c);
            end else $display("ok   stats_reset[%0d] cnt=%0d", k, got_c[k]);
        end
        for (int i = 0; i < 5; i++) apply(S_LU);
        for (int i = 0; i < 4; i++) apply(S_DW);
        for (int i = 0; i < 2; i++) apply(S_BRHIT);
        apply(S_IDLE);
        cnt_sb.push_back(5); cnt_sb.push_back(4); cnt_sb.push_back(2);
        cnt_sb.push_back(3); cnt_sb.push_back(3); cnt_sb.push_back(2);
        @(negedge clk);
        got_c = '{int'(lu_cnt), int'(dwait_cnt), int'(flush_cnt),
                  int'(lu_cnt2), int'(dwait_cnt2), int'(flush_cnt2)};
        for (int k = 0; k < 6; k++) begin
            want_c = cnt_sb.pop_front();
            checks++;
            if (got_c[k] !== want_c) begin
                errors++;
                $display("FAIL stats_count[%0d] got=%0d want=%0d", k, got_c[k], want_c);
            end else $display("ok   stats_count[%0d] cnt=%0d", k, got_c[k]);
        end
        // Counters freeze in HALTED even with stall-looking inputs.
        apply(S_HALT);
        for (int i = 0; i < 3; i++) apply(S_DWALL);
        cnt_sb.push_back(5); cnt_sb.push_back(4); cnt_sb.push_back(2);
        @(negedge clk);
        got_c[0] = int'(lu_cnt);
        got_c[1] = int'(dwait_cnt);
        got_c[2] = int'(flush_cnt);
        for (int k = 0; k < 3; k++) begin
            want_c = cnt_sb.pop_front();
            checks++;
            if (got_c[k] !== want_c) begin
                errors++;
                $display("FAIL stats_frozen[%0d] got=%0d want=%0d", k, got_c[k], want_c);
            end else $display("ok   stats_frozen[%0d] cnt=%0d", k, got_c[k]);
        end
        apply(S_RST);
        apply(S_IDLE);
    endtask
`endif

    initial begin
        test_reset();
        test_load_use();
        test_dwait();
        test_squash();
        test_halt();
        test_reset_squash();
`ifdef STALL_STATS_EN
        test_stats();
`endif
        $display("Result: errors=%0d of %0d checks", errors, checks);
        $finish;
    end

endmodule
